// File: rtl/grid_access_ctrl_if.sv
// grid_access_ctrl_if: bundles the grid write-port controller's handshake and write-port signals.
//   master : requester side (drives clear_req, A/B requests; observes readies and write port)
//   slave  : controller side (accepts requests, drives readies, clear_busy and the write port)
//   clear_req/clear_busy          : full-grid clear request and sweep-in-progress flag
//   a_*/b_* (valid,row,col,data)  : two cell-write requesters, with ready back to each
//   wr_en/wr_addr/wr_data         : registered grid write port
//   err_oob                       : one-cycle pulse when an accepted request was out of range
interface grid_access_ctrl_if #(
    parameter int unsigned ROW_W  = 5,
    parameter int unsigned COL_W  = 6,
    parameter int unsigned ADDR_W = 11
);
    logic              clear_req;
    logic              clear_busy;

    logic              a_valid;
    logic [ROW_W-1:0]  a_row;
    logic [COL_W-1:0]  a_col;
    logic              a_data;
    logic              a_ready;

    logic              b_valid;
    logic [ROW_W-1:0]  b_row;
    logic [COL_W-1:0]  b_col;
    logic              b_data;
    logic              b_ready;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              err_oob;

    modport master (
        output clear_req,
        output a_valid, a_row, a_col, a_data,
        output b_valid, b_row, b_col, b_data,
        input  clear_busy, a_ready, b_ready,
        input  wr_en, wr_addr, wr_data, err_oob
    );

    modport slave (
        input  clear_req,
        input  a_valid, a_row, a_col, a_data,
        input  b_valid, b_row, b_col, b_data,
        output clear_busy, a_ready, b_ready,
        output wr_en, wr_addr, wr_data, err_oob
    );
endinterface

// File: rtl/grid_access_ctrl.sv
// grid_access_ctrl: write-port controller for the GRID_ROWS x GRID_COLS 1-bit video cell grid.
// Round-robin arbitration between requester A (CPU bridge) and B (logic engine), plus a
// full-grid clear sweep. The grid write port is fully registered.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : grid_access_ctrl_if.slave (clear request/busy, A/B requests and readies,
//              wr_en/wr_addr/wr_data write port, err_oob pulse)
module grid_access_ctrl #(
    parameter int unsigned GRID_ROWS = 30,
    parameter int unsigned GRID_COLS = 40,
    parameter int unsigned ROW_W     = 5,
    parameter int unsigned COL_W     = 6,
    parameter int unsigned ADDR_W    = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    grid_access_ctrl_if.slave  bus
);

    localparam int unsigned      NumCells = GRID_ROWS * GRID_COLS;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumCells - 1);
    localparam logic [ADDR_W-1:0] ColsA    = ADDR_W'(GRID_COLS);
    // One extra bit so the limit compare cannot wrap for any coordinate value.
    localparam logic [ROW_W:0]   RowLimit = (ROW_W + 1)'(GRID_ROWS);
    localparam logic [COL_W:0]   ColLimit = (COL_W + 1)'(GRID_COLS);

    typedef enum logic [0:0] {StIdle, StClear} state_e;
    typedef enum logic [0:0] {GrantA, GrantB} grant_e;

    state_e            state_q;
    grant_e            last_grant_q;
    logic [ADDR_W-1:0] sweep_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wr_data_q;
    logic              err_oob_q;
    logic              clear_busy_q;

    logic              arb_open;
    logic              grant_a;
    logic              grant_b;
    logic [ROW_W-1:0]  sel_row;
    logic [COL_W-1:0]  sel_col;
    logic              sel_data;
    logic              sel_oob;
    logic [ADDR_W-1:0] sel_addr;

    // Readies are combinational; clear_req pre-empts any pending request in IDLE.
    always_comb begin
        arb_open = (state_q == StIdle) && !bus.clear_req;
        // On a tie the requester that did not win last time is served.
        grant_a  = arb_open && bus.a_valid && (!bus.b_valid || (last_grant_q == GrantB));
        grant_b  = arb_open && bus.b_valid && (!bus.a_valid || (last_grant_q == GrantA));
        sel_row  = grant_b ? bus.b_row  : bus.a_row;
        sel_col  = grant_b ? bus.b_col  : bus.a_col;
        sel_data = grant_b ? bus.b_data : bus.a_data;
        sel_oob  = ({1'b0, sel_row} >= RowLimit) || ({1'b0, sel_col} >= ColLimit);
        sel_addr = ADDR_W'(sel_row) * ColsA + ADDR_W'(sel_col);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= GrantB;
            sweep_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 1'b0;
            err_oob_q    <= 1'b0;
            clear_busy_q <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            err_oob_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.clear_req) begin
                        // First sweep write (address 0) appears the very next cycle.
                        state_q      <= StClear;
                        sweep_q      <= '0;
                        clear_busy_q <= 1'b1;
                        wr_en_q      <= 1'b1;
                        wr_addr_q    <= '0;
                        wr_data_q    <= 1'b0;
                    end else if (grant_a || grant_b) begin
                        last_grant_q <= grant_a ? GrantA : GrantB;
                        if (sel_oob) begin
                            // Consumed but dropped; write port keeps its old address/data.
                            err_oob_q <= 1'b1;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= sel_addr;
                            wr_data_q <= sel_data;
                        end
                    end
                end
                StClear: begin
                    // sweep_q tracks the address currently on the write port.
                    if (sweep_q == LastAddr) begin
                        state_q      <= StIdle;
                        sweep_q      <= '0;
                        clear_busy_q <= 1'b0;
                    end else begin
                        sweep_q   <= sweep_q + ADDR_W'(1);
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= sweep_q + ADDR_W'(1);
                        wr_data_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.a_ready    = grant_a;
    assign bus.b_ready    = grant_b;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.err_oob    = err_oob_q;
    assign bus.clear_busy = clear_busy_q;

endmodule

// File: tb/tb_grid_access_ctrl.sv
// Testbench for grid_access_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of the write port, with literal expectations pinning the model.
module tb_grid_access_ctrl;

    localparam int GRID_ROWS = 30;
    localparam int GRID_COLS = 40;
    localparam int ROW_W     = 5;
    localparam int COL_W     = 6;
    localparam int ADDR_W    = 11;
    localparam int N         = GRID_ROWS * GRID_COLS;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    grid_access_ctrl_if #(.ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W)) bus ();

    grid_access_ctrl #(
        .GRID_ROWS(GRID_ROWS),
        .GRID_COLS(GRID_COLS),
        .ROW_W(ROW_W),
        .COL_W(COL_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: every accepted action schedules write-port events in a queue; each clock pops one.
    typedef struct {
        bit en;
        int addr;
        bit data;
        bit busy;
        bit err;
    } wevt_t;

    wevt_t evq[$];
    bit exp_en, exp_data, exp_busy, exp_err, exp_ar, exp_br;
    int exp_addr;
    bit last_b;     // 1 when B holds the most recent grant
    bit check_en = 1'b0;
    bit last_ar, last_br;

    task automatic model_reset();
        evq.delete();
        exp_en = 0; exp_addr = 0; exp_data = 0; exp_busy = 0; exp_err = 0;
        exp_ar = 0; exp_br = 0; last_b = 1;
    endtask

    task automatic model_eval();
        exp_ar = 0;
        exp_br = 0;
        if (!exp_busy && !bus.clear_req) begin
            if (bus.a_valid && (!bus.b_valid || last_b)) exp_ar = 1;
            else if (bus.b_valid && (!bus.a_valid || !last_b)) exp_br = 1;
        end
    endtask

    function automatic wevt_t req_evt(input int row, input int col, input bit data);
        wevt_t e;
        bit oob = (row >= GRID_ROWS) || (col >= GRID_COLS);
        e.en = !oob; e.addr = row * GRID_COLS + col; e.data = data; e.busy = 0; e.err = oob;
        return e;
    endfunction

    task automatic model_edge();
        wevt_t e;
        if (!exp_busy && bus.clear_req) begin
            for (int k = 0; k < N; k++) begin
                e.en = 1; e.addr = k; e.data = 0; e.busy = 1; e.err = 0;
                evq.push_back(e);
            end
        end else if (exp_ar) begin
            evq.push_back(req_evt(int'(bus.a_row), int'(bus.a_col), bus.a_data));
            last_b = 0;
        end else if (exp_br) begin
            evq.push_back(req_evt(int'(bus.b_row), int'(bus.b_col), bus.b_data));
            last_b = 1;
        end
        if (evq.size() > 0) begin
            e = evq.pop_front();
            exp_en = e.en; exp_busy = e.busy; exp_err = e.err;
            if (e.en) begin
                exp_addr = e.addr;
                exp_data = e.data;
            end
        end else begin
            exp_en = 0; exp_busy = 0; exp_err = 0;
        end
    endtask

    // Inputs are set at posedge+1; readies sampled at posedge+2; outputs visible at return.
    task automatic cycle();
        #1;
        model_eval();
        last_ar = bus.a_ready;
        last_br = bus.b_ready;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("wr_en", int'(bus.wr_en), int'(exp_en));
            chk("wr_addr", int'(bus.wr_addr), exp_addr);
            chk("wr_data", int'(bus.wr_data), int'(exp_data));
            chk("err_oob", int'(bus.err_oob), int'(exp_err));
            chk("clear_busy", int'(bus.clear_busy), int'(exp_busy));
            chk("a_ready", int'(bus.a_ready), int'(exp_ar));
            chk("b_ready", int'(bus.b_ready), int'(exp_br));
        end
    end

    task automatic idle_inputs();
        bus.clear_req = 0;
        bus.a_valid = 0; bus.a_row = '0; bus.a_col = '0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_row = '0; bus.b_col = '0; bus.b_data = 0;
    endtask

    task automatic set_a(input int row, input int col, input bit data);
        bus.a_valid = 1; bus.a_row = ROW_W'(row); bus.a_col = COL_W'(col); bus.a_data = data;
    endtask

    task automatic set_b(input int row, input int col, input bit data);
        bus.b_valid = 1; bus.b_row = ROW_W'(row); bus.b_col = COL_W'(col); bus.b_data = data;
    endtask

    task automatic rand_a();
        set_a(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 29),
              ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 39),
              1'($urandom_range(0, 1)));
    endtask

    task automatic rand_b();
        set_b(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 29),
              ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 39),
              1'($urandom_range(0, 1)));
    endtask

    initial begin
        int exp_list[4];
        int grants[4];
        int busy_cnt, first_a, seq_err;
        bit found;

        exp_list = '{41, 80, 42, 81};
        idle_inputs();
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_clear_busy", int'(bus.clear_busy), 0);
        chk("rst_err_oob", int'(bus.err_oob), 0);
        chk("rst_a_ready", int'(bus.a_ready), 0);
        chk("rst_b_ready", int'(bus.b_ready), 0);
        reset_n = 1;
        check_en = 1;
        cycle();
        cycle();

        // Single A write: row 2, col 3
        set_a(2, 3, 1);
        cycle();
        bus.a_valid = 0;
        chk("t1_a_ready", int'(last_ar), 1);
        chk("t1_wr_en", int'(bus.wr_en), 1);
        chk("t1_wr_addr", int'(bus.wr_addr), 83);
        chk("t1_wr_data", int'(bus.wr_data), 1);
        cycle();

        // Lone B write hands last_grant to B, so A wins the next tie
        set_b(0, 0, 0);
        cycle();
        bus.b_valid = 0;
        cycle();

        // Both valid for 4 cycles: A,B,A,B
        set_a(1, 1, 1);
        set_b(2, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            grants[i] = last_ar ? 1 : (last_br ? 2 : 0);
            chk("rr_wr_en", int'(bus.wr_en), 1);
            chk("rr_wr_addr", int'(bus.wr_addr), exp_list[i]);
            if (last_ar) set_a(1, 2, 0);
            if (last_br) set_b(2, 1, 0);
        end
        chk("rr_grant0", grants[0], 1);
        chk("rr_grant1", grants[1], 2);
        chk("rr_grant2", grants[2], 1);
        chk("rr_grant3", grants[3], 2);
        idle_inputs();
        cycle();

        // Clear pulse with A held
        set_a(3, 4, 1);
        bus.clear_req = 1;
        cycle();
        bus.clear_req = 0;
        chk("clr_a_ready_t", int'(last_ar), 0);
        busy_cnt = 0; first_a = 0; seq_err = 0;
        for (int k = 1; k <= 1300; k++) begin
            if (bus.clear_busy) begin
                busy_cnt++;
                if (int'(bus.wr_addr) != k - 1 || bus.wr_data || !bus.wr_en) seq_err++;
            end
            cycle();
            if (last_ar) begin
                first_a = k;
                break;
            end
        end
        bus.a_valid = 0;
        chk("clr_busy_cycles", busy_cnt, N);
        chk("clr_addr_seq_errors", seq_err, 0);
        chk("clr_first_a_ready", first_a, N + 1);
        cycle();

        // Out-of-range B request: row 30
        set_b(30, 0, 1);
        cycle();
        bus.b_valid = 0;
        chk("oob_b_ready", int'(last_br), 1);
        chk("oob_err", int'(bus.err_oob), 1);
        chk("oob_wr_en", int'(bus.wr_en), 0);
        chk("oob_wr_addr_hold", int'(bus.wr_addr), 124);
        cycle();
        chk("oob_err_one_cycle", int'(bus.err_oob), 0);

        // Clear held high across a full sweep restarts immediately
        bus.clear_req = 1;
        busy_cnt = 0;
        for (int k = 0; k < 1202; k++) begin
            cycle();
            if (bus.clear_busy) busy_cnt++;
        end
        bus.clear_req = 0;
        for (int k = 0; k < 1300; k++) begin
            cycle();
            if (bus.clear_busy) busy_cnt++;
        end
        chk("held_clear_busy_cycles", busy_cnt, 2 * N);

        // Reset in the middle of a sweep
        bus.clear_req = 1;
        cycle();
        bus.clear_req = 0;
        found = 0;
        for (int k = 0; k < 1300; k++) begin
            if (bus.clear_busy && int'(bus.wr_addr) == 500) begin
                found = 1;
                break;
            end
            cycle();
        end
        chk("mid_reach_addr_500", int'(found), 1);
        check_en = 0;
        reset_n = 0;
        #1;
        chk("mid_rst_wr_en", int'(bus.wr_en), 0);
        chk("mid_rst_wr_addr", int'(bus.wr_addr), 0);
        chk("mid_rst_clear_busy", int'(bus.clear_busy), 0);
        chk("mid_rst_err_oob", int'(bus.err_oob), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        check_en = 1;
        cycle();
        chk("post_rst_idle_busy", int'(bus.clear_busy), 0);
        set_a(5, 5, 1);
        cycle();
        bus.a_valid = 0;
        chk("post_rst_a_ready", int'(last_ar), 1);
        chk("post_rst_wr_addr", int'(bus.wr_addr), 205);
        chk("post_rst_wr_en", int'(bus.wr_en), 1);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if (!bus.a_valid) begin
                if ($urandom_range(0, 2) == 0) rand_a();
            end else if ($urandom_range(0, 19) == 0) begin
                bus.a_valid = 0;
            end
            if (!bus.b_valid) begin
                if ($urandom_range(0, 2) == 0) rand_b();
            end else if ($urandom_range(0, 19) == 0) begin
                bus.b_valid = 0;
            end
            bus.clear_req = ($urandom_range(0, 599) == 0);
            cycle();
            if (last_ar) bus.a_valid = 0;
            if (last_br) bus.b_valid = 0;
        end
        idle_inputs();
        cycle();
        cycle();

        check_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
